demux_1x256_reg: RTL and testbench

DEMUX_1X256_REG -- requirements
Module: demux_1x256_reg

---
 rtl/demux_pkg.sv | 20 ++
 rtl/demux_bit_reg.sv | 43 ++++
 rtl/demux_1x256_reg.sv | 96 +++++++++
 tb/tb_demux_1x256_reg.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// demux_pkg: shared constants and the one-hot write decoder for the
// 1-to-256 registered demultiplexer.
//   DEMUX_WIDTH : number of output bits in the bank
//   SEL_W       : width of the destination index
//   CNT_W       : width of the landed-write counter
package demux_pkg;

    localparam int DEMUX_WIDTH = 256;
    localparam int SEL_W       = 8;
    localparam int CNT_W       = 16;

    // One-hot decode of an index into write enables; all-zero when en is low.
    function automatic logic [DEMUX_WIDTH-1:0] onehot_dec(
        input logic             en,
        input logic [SEL_W-1:0] idx
    );
        return {{(DEMUX_WIDTH-1){1'b0}}, en} << idx;
    endfunction

endpackage : demux_pkg

// File: rtl/demux_bit_reg.sv
// demux_bit_reg: one bit of the output bank.
//   clk : clock, rising edge
//   rst : synchronous active-high reset, clears q
//   clr : synchronous clear, clears q (wins over we)
//   we  : write enable for this bit
//   d   : data bit to store when we is high
//   q   : registered stored bit
module demux_bit_reg (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic we,
    input  logic d,
    output logic q
);

    logic q_d;
    logic q_q;

    // Next value: clear dominates write, otherwise hold.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = 1'b0;
        end else if (we) begin
            q_d = d;
        end else begin
            q_d = q_q;
        end
    end

    // Storage flop with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule : demux_bit_reg

// File: rtl/demux_1x256_reg.sv
// demux_1x256_reg: two-stage registered 1-to-256 demultiplexer.
// Edge E captures (in_valid, in, sel) into stage 1; edge E+1 writes the
// stage-1 bit into out[sel], raises out_valid for one cycle and counts it.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   in_valid  : write request
//   in        : data bit to distribute
//   sel       : destination index
//   clr       : synchronous clear of the output bank and of stage 1
//   out       : registered output bank
//   out_valid : one-cycle pulse when a write has landed
//   out_sel   : index of the landed write, held otherwise
//   wr_count  : wrapping count of landed writes (not affected by clr)
module demux_1x256_reg
    import demux_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic                   in,
    input  logic [SEL_W-1:0]       sel,
    input  logic                   clr,
    output logic [DEMUX_WIDTH-1:0] out,
    output logic                   out_valid,
    output logic [SEL_W-1:0]       out_sel,
    output logic [CNT_W-1:0]       wr_count
);

    logic             s1_valid_d, s1_valid_q;
    logic             s1_data_d,  s1_data_q;
    logic [SEL_W-1:0] s1_sel_d,   s1_sel_q;
    logic             out_valid_d, out_valid_q;
    logic [SEL_W-1:0] out_sel_d,   out_sel_q;
    logic [CNT_W-1:0] wr_count_d,  wr_count_q;
    logic             land_s;
    logic [DEMUX_WIDTH-1:0] we_s;
    logic [DEMUX_WIDTH-1:0] out_bits_s;

    // Next-state for stage 1 and the status outputs.
    always_comb begin
        // A write arriving with clr is dropped at the door.
        s1_valid_d  = in_valid & ~clr;
        s1_data_d   = in;
        s1_sel_d    = sel;
        // A pending stage-1 write is cancelled by clr at the same edge.
        land_s      = s1_valid_q & ~clr;
        out_valid_d = land_s;
        if (land_s) begin
            out_sel_d  = s1_sel_q;
            wr_count_d = wr_count_q + CNT_W'(1);
        end else begin
            out_sel_d  = out_sel_q;
            wr_count_d = wr_count_q;
        end
    end

    // Stage-1 and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= 1'b0;
            s1_sel_q    <= {SEL_W{1'b0}};
            out_valid_q <= 1'b0;
            out_sel_q   <= {SEL_W{1'b0}};
            wr_count_q  <= {CNT_W{1'b0}};
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_sel_q    <= s1_sel_d;
            out_valid_q <= out_valid_d;
            out_sel_q   <= out_sel_d;
            wr_count_q  <= wr_count_d;
        end
    end

    // Single decoder driven only from stage-1 registers; clr masking happens
    // inside each bit, so no input reaches out combinationally.
    assign we_s = onehot_dec(s1_valid_q, s1_sel_q);

    for (genvar g = 0; g < DEMUX_WIDTH; g++) begin : g_bit
        demux_bit_reg u_bit (
            .clk (clk),
            .rst (rst),
            .clr (clr),
            .we  (we_s[g]),
            .d   (s1_data_q),
            .q   (out_bits_s[g])
        );
    end

    assign out       = out_bits_s;
    assign out_valid = out_valid_q;
    assign out_sel   = out_sel_q;
    assign wr_count  = wr_count_q;

endmodule : demux_1x256_reg

// File: tb/tb_demux_1x256_reg.sv
// Testbench for demux_1x256_reg: directed stimulus pushes the expected
// landing (index, bit, count, cycle) into a scoreboard queue; a monitor pops
// and compares on every out_valid pulse. Bank snapshots are checked against
// hand-computed vectors at quiet points.
module tb_demux_1x256_reg;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in;
    logic [7:0]   sel;
    logic         clr;
    logic [255:0] out;
    logic         out_valid;
    logic [7:0]   out_sel;
    logic [15:0]  wr_count;

    typedef struct {
        logic [7:0]  sel;
        logic        d;
        logic [15:0] cnt;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          compared = 0;
    int          failed   = 0;
    int          cyc      = 0;
    logic [15:0] exp_cnt  = 16'd0;
    logic [255:0] ones;
    logic [255:0] vec;

    demux_1x256_reg dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in        (in),
        .sel       (sel),
        .clr       (clr),
        .out       (out),
        .out_valid (out_valid),
        .out_sel   (out_sel),
        .wr_count  (wr_count)
    );

    always #5 clk = ~clk;

    // Cycle counter used for latency checks.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge; push expectation if it lands.
    task automatic drive(input logic v, input logic d, input logic [7:0] s,
                         input logic c, input logic lands);
        exp_t e;
        @(negedge clk);
        in_valid = v; in = d; sel = s; clr = c;
        if (lands) begin
            exp_cnt = exp_cnt + 16'd1;
            e.sel = s; e.d = d; e.cnt = exp_cnt; e.cyc = cyc + 2;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // Monitor: every out_valid pulse must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    compared++;
                    failed++;
                    $display("FAIL unexpected_out_valid: out_sel=%0h required=no pulse", out_sel);
                end else begin
                    e = sb.pop_front();
                    chk("out_sel", {248'd0, out_sel}, {248'd0, e.sel});
                    chk("out_bit", {255'd0, out[e.sel]}, {255'd0, e.d});
                    chk("wr_count_at_land", {240'd0, wr_count}, {240'd0, e.cnt});
                    chk("latency_cycle", 256'(cyc), 256'(e.cyc));
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ones = '1;
        rst = 1'b1; in_valid = 1'b0; in = 1'b0; sel = 8'h00; clr = 1'b0;
        // Reset held for two edges.
        @(negedge clk); @(negedge clk);
        chk("reset_out", out, 256'd0);
        chk("reset_out_valid", {255'd0, out_valid}, 256'd0);
        chk("reset_wr_count", {240'd0, wr_count}, 256'd0);
        chk("reset_out_sel", {248'd0, out_sel}, 256'd0);
        rst = 1'b0;

        // Single writes to both ends of the bank.
        drive(1'b1, 1'b1, 8'h00, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 8'hFF, 1'b0, 1'b1);
        idle(3);
        chk("single_out", out, {1'b1, 254'd0, 1'b1});
        chk("single_wr_count", {240'd0, wr_count}, 256'd2);

        // Stream all 256 indices back to back.
        for (int i = 0; i < 256; i++) drive(1'b1, 1'b1, 8'(i), 1'b0, 1'b1);
        idle(3);
        chk("stream_out", out, ones);
        chk("stream_wr_count", {240'd0, wr_count}, 256'd258);

        // Same index twice: last write wins.
        drive(1'b1, 1'b1, 8'h10, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 8'h10, 1'b0, 1'b1);
        idle(3);
        vec = ones;
        vec[16] = 1'b0;
        chk("overwrite_out", out, vec);
        chk("overwrite_wr_count", {240'd0, wr_count}, 256'd260);
        drive(1'b1, 1'b1, 8'h10, 1'b0, 1'b1);
        idle(3);
        chk("restore_out", out, ones);

        // Pending write cancelled by clr on the following edge.
        drive(1'b1, 1'b1, 8'h20, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        idle(3);
        chk("clear_out", out, 256'd0);
        chk("clear_wr_count", {240'd0, wr_count}, 256'd261);

        // clr with in_valid on the same edge: write dropped.
        drive(1'b1, 1'b1, 8'h05, 1'b1, 1'b0);
        idle(3);
        chk("clr_same_edge_out", out, 256'd0);
        chk("clr_same_edge_wr_count", {240'd0, wr_count}, 256'd261);

        // in/sel ignored without in_valid.
        drive(1'b0, 1'b1, 8'h30, 1'b0, 1'b0);
        idle(3);
        chk("no_valid_out", out, 256'd0);

        // A lone write, then out_sel must hold while out_valid is low.
        drive(1'b1, 1'b1, 8'h07, 1'b0, 1'b1);
        idle(4);
        vec = 256'd0;
        vec[7] = 1'b1;
        chk("lone_out", out, vec);
        chk("out_sel_hold", {248'd0, out_sel}, 256'h07);
        chk("out_valid_low", {255'd0, out_valid}, 256'd0);
        chk("lone_wr_count", {240'd0, wr_count}, 256'd262);

        // Reset on the edge after a write is sampled: it never lands.
        drive(1'b1, 1'b1, 8'h40, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 16'd0;
        idle(3);
        chk("midrst_out", out, 256'd0);
        chk("midrst_wr_count", {240'd0, wr_count}, 256'd0);
        chk("midrst_out_sel", {248'd0, out_sel}, 256'd0);
        chk("midrst_out_valid", {255'd0, out_valid}, 256'd0);
        drive(1'b1, 1'b1, 8'h41, 1'b0, 1'b1);
        idle(3);
        vec = 256'd0;
        vec[65] = 1'b1;
        chk("post_rst_out", out, vec);
        chk("post_rst_wr_count", {240'd0, wr_count}, 256'd1);

        // Every expected landing must have been seen.
        idle(2);
        chk("scoreboard_empty", 256'(sb.size()), 256'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule : tb_demux_1x256_reg
